// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// bcd_pkg : shared types and constants for the binary-to-BCD converter
// Rev 1.0
// ============================================================================
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [3:0] DIGIT_NINE  = 4'h9;

    function automatic int unsigned max_val(input int unsigned digits);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
// bcd_add3 : one double-dabble digit correction stage (+3 when digit >= 5)
// Rev 1.0
// ============================================================================
module bcd_add3 (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // Inputs never exceed 9 in a valid scratch, so the sum fits in 4 bits.
    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// bin2bcd_seq : sequential double-dabble binary-to-BCD converter, 1 bit/clock
// Optional macro BIN2BCD_BLANK_LEADING_EN blanks leading zero digits (4'hF).
// Rev 1.0
// ============================================================================
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int              BCD_W  = 4 * DIGITS;
    localparam int              CNT_W  = $clog2(BIN_W + 1);
    localparam logic [31:0]     c_MAX  = 32'(max_val(DIGITS));
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(BIN_W - 1);

    state_t             r_state;
    state_t             w_next;
    logic [BIN_W-1:0]   r_bin;
    logic [BCD_W-1:0]   r_scratch;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_final;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_pend;
    logic               r_done;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_overflow;
    logic               w_last;

    assign w_last   = (r_cnt == c_LAST);
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_overflow;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .i_digit (r_scratch[4*g +: 4]),
                .o_digit (w_adj[4*g +: 4])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = LATCH;
            LATCH:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Leading-zero blanking scans from the MSD down; digit 0 always shows.
    always_comb begin
        w_final = r_scratch;
`ifdef BIN2BCD_BLANK_LEADING_EN
        begin : blank_scan
            logic w_lead;
            w_lead = 1'b1;
            for (int d = DIGITS - 1; d > 0; d--) begin
                if (w_lead && (r_scratch[4*d +: 4] == 4'h0)) begin
                    w_final[4*d +: 4] = DIGIT_BLANK;
                end else begin
                    w_lead = 1'b0;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bin      <= '0;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin      <= bin;
                        r_scratch  <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= (32'(bin) > c_MAX);
                    end
                end
                SHIFT: begin
                    // Bits pushed past the top digit are dropped; saturation covers them.
                    {r_scratch, r_bin} <= {w_adj[BCD_W-2:0], r_bin, 1'b0};
                    r_cnt              <= r_cnt + 1'b1;
                end
                LATCH: begin
                    r_bcd      <= r_ovf_pend ? {DIGITS{DIGIT_NINE}} : w_final;
                    r_overflow <= r_ovf_pend;
                    r_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
